// File: rtl/fir_stream_driver.sv
`default_nettype none
// ============================================================================
//  Module      : fir_stream_driver
//  Description : Plays a host-loaded sample buffer into a FIR, one go strobe
//                per sample, and captures each FIR result for host read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_stream_driver #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int LAT   = 1,
    parameter int GAP   = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          start,
    input  logic [AW:0]   count,
    output logic [7:0]    fir_in,
    output logic          fir_go,
    input  logic [15:0]   fir_y,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic          busy,
    output logic          done
);

    localparam int WW = (LAT + GAP + 1 > 1) ? $clog2(LAT + GAP + 1) : 1;

    localparam logic [WW-1:0] c_wait_load = WW'(LAT + GAP);
    localparam logic [WW-1:0] c_cap_cnt   = WW'(GAP + 1);
    localparam logic [WW-1:0] c_wait_one  = WW'(1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   c_idx_one   = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [AW:0]   idx, idx_nx;
    logic [AW:0]   n, n_nx;
    logic [WW-1:0] wcnt, wcnt_nx;
    logic          capture;

    logic [7:0]    sample_mem [DEPTH];
    logic [15:0]   result_mem [DEPTH];

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        n_nx     = n;
        wcnt_nx  = wcnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    n_nx     = (count > c_depth) ? c_depth : count;
                    idx_nx   = '0;
                    state_nx = (n_nx == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                wcnt_nx  = c_wait_load;
                state_nx = WAIT;
            end
            WAIT: begin
                // wcnt counts down from LAT+GAP; it equals GAP+1 on the LAT-th wait cycle
                capture = (wcnt == c_cap_cnt);
                if (wcnt == c_wait_one) begin
                    idx_nx   = idx + c_idx_one;
                    state_nx = (idx_nx == n) ? FIN : SEND;
                end else begin
                    wcnt_nx = wcnt - c_wait_one;
                end
            end
            FIN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            n       <= '0;
            wcnt    <= '0;
            fir_in  <= 8'd0;
            fir_go  <= 1'b0;
            rd_data <= 16'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            n       <= n_nx;
            wcnt    <= wcnt_nx;
            fir_go  <= (state_nx == SEND);
            busy    <= (state_nx != IDLE);
            done    <= (state_nx == FIN);
            rd_data <= result_mem[rd_addr];
            if (state_nx == SEND) begin
                fir_in <= sample_mem[idx_nx[AW-1:0]];
            end
        end
    end

    // Buffers are deliberately left out of reset so captured results survive an abort
    always_ff @(posedge clk) begin
        if (wr_en && (state == IDLE)) begin
            sample_mem[wr_addr] <= wr_data;
        end
        if (capture) begin
            result_mem[idx[AW-1:0]] <= fir_y;
        end
    end

endmodule
`default_nettype wire
